// File: rtl/adder_operand_ctrl_pkg.sv
// Shared constants for the two-operand entry controller: mode encoding, data widths,
// button indices and the small helpers used by the top-level FSM.
package adder_operand_ctrl_pkg;

  localparam int OP_W   = 8;
  localparam int DISP_W = 9;

  typedef logic [1:0] mode_t;

  localparam mode_t EDIT_A = 2'd0;
  localparam mode_t EDIT_B = 2'd1;
  localparam mode_t SHOW   = 2'd2;

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_SEL  = 2;
  localparam int BTN_CLR  = 3;
  localparam int NUM_BTN  = 4;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      EDIT_A:  return EDIT_B;
      EDIT_B:  return SHOW;
      default: return EDIT_A;
    endcase
  endfunction

  // The sum is formed at display width so the carry out of the 8-bit add is kept.
  function automatic logic [DISP_W-1:0] disp_mux(input mode_t m,
                                                 input logic [OP_W-1:0] a,
                                                 input logic [OP_W-1:0] b);
    case (m)
      EDIT_A:  return {1'b0, a};
      EDIT_B:  return {1'b0, b};
      SHOW:    return DISP_W'(a) + DISP_W'(b);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/adder_operand_ctrl_if.sv
// Button inputs and display/operand outputs of the operand controller.
// master = button/display side, slave = controller.
interface adder_operand_ctrl_if;
  import adder_operand_ctrl_pkg::*;

  logic              btn_sel;
  logic              btn_up;
  logic              btn_down;
  logic              btn_clr;
  logic [DISP_W-1:0] disp_val;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  mode_t             mode;

  modport master (
    output btn_sel, btn_up, btn_down, btn_clr,
    input  disp_val, op_a, op_b, mode
  );

  modport slave (
    input  btn_sel, btn_up, btn_down, btn_clr,
    output disp_val, op_a, op_b, mode
  );
endinterface

// File: rtl/adder_operand_ctrl_btn_debounce.sv
// One raw button: 2-flop synchronizer, stable-level debouncer and registered press pulse.
// The level output exists only when ADDER_OPERAND_AUTO_REPEAT_EN is defined.
module btn_debounce #(
  parameter int DEBOUNCE_CNT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
`ifdef ADDER_OPERAND_AUTO_REPEAT_EN
  output logic level_o,
`endif
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample matching the accepted level restarts the count, so bounces never accumulate.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CNT)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;
`ifdef ADDER_OPERAND_AUTO_REPEAT_EN
  assign level_o = level_q;
`endif

endmodule

// File: rtl/adder_operand_ctrl.sv
// Operand entry controller: debounced buttons drive an EDIT_A/EDIT_B/SHOW FSM and two
// 8-bit operands; define ADDER_OPERAND_AUTO_REPEAT_EN to add hold-to-repeat on up/down.
module adder_operand_ctrl
  import adder_operand_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  adder_operand_ctrl_if.slave  bus
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  mode_t             mode_q, mode_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic [DISP_W-1:0] disp_q;
  logic              step_up, step_dn;

  assign btn_raw[BTN_UP]   = bus.btn_up;
  assign btn_raw[BTN_DOWN] = bus.btn_down;
  assign btn_raw[BTN_SEL]  = bus.btn_sel;
  assign btn_raw[BTN_CLR]  = bus.btn_clr;

`ifdef ADDER_OPERAND_AUTO_REPEAT_EN
  logic [NUM_BTN-1:0] level;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
      ) u_db (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_raw[gi]),
`ifdef ADDER_OPERAND_AUTO_REPEAT_EN
        .level_o(level[gi]),
`endif
        .press_o(press[gi])
      );
    end
  endgenerate

`ifdef ADDER_OPERAND_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic             rep_armed_q, rep_armed_d;
  logic             rep_first_q, rep_first_d;
  logic             rep_dn_q, rep_dn_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [REP_W-1:0] rep_lim;
  logic             editing, rep_held, rep_hit, rep_step;

  assign editing  = (mode_q == EDIT_A) || (mode_q == EDIT_B);
  assign rep_held = rep_dn_q ? level[BTN_DOWN] : level[BTN_UP];
  assign rep_lim  = rep_first_q ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_RATE - 1);
  assign rep_hit  = (rep_cnt_q == rep_lim);
  assign rep_step = rep_armed_q & rep_held & editing & rep_hit & ~(|press);

  // Every press re-arms or kills the repeat; only a lone up/down press in an edit mode arms it.
  always_comb begin
    rep_armed_d = rep_armed_q;
    rep_first_d = rep_first_q;
    rep_dn_d    = rep_dn_q;
    rep_cnt_d   = rep_cnt_q;
    if (|press) begin
      rep_armed_d = editing & ~press[BTN_CLR] & ~press[BTN_SEL]
                  & (press[BTN_UP] ^ press[BTN_DOWN]);
      rep_first_d = 1'b1;
      rep_dn_d    = press[BTN_DOWN];
      rep_cnt_d   = '0;
    end else if (rep_armed_q && rep_held && editing) begin
      if (rep_hit) begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end else begin
      rep_armed_d = 1'b0;
      rep_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_armed_q <= 1'b0;
      rep_first_q <= 1'b0;
      rep_dn_q    <= 1'b0;
      rep_cnt_q   <= '0;
    end else begin
      rep_armed_q <= rep_armed_d;
      rep_first_q <= rep_first_d;
      rep_dn_q    <= rep_dn_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end
`endif

  always_comb begin
    mode_d  = mode_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (press[BTN_CLR]) begin
      mode_d = EDIT_A;
      op_a_d = '0;
      op_b_d = '0;
    end else if (press[BTN_SEL]) begin
      mode_d = next_mode(mode_q);
    end else begin
      step_up = press[BTN_UP] & ~press[BTN_DOWN];
      step_dn = press[BTN_DOWN] & ~press[BTN_UP];
`ifdef ADDER_OPERAND_AUTO_REPEAT_EN
      step_up = step_up | (rep_step & ~rep_dn_q);
      step_dn = step_dn | (rep_step & rep_dn_q);
`endif
      if (mode_q == EDIT_A) begin
        if (step_up)      op_a_d = op_a_q + OP_W'(1);
        else if (step_dn) op_a_d = op_a_q - OP_W'(1);
      end else if (mode_q == EDIT_B) begin
        if (step_up)      op_b_d = op_b_q + OP_W'(1);
        else if (step_dn) op_b_d = op_b_q - OP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= EDIT_A;
      op_a_q <= '0;
      op_b_q <= '0;
      disp_q <= '0;
    end else begin
      mode_q <= mode_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      disp_q <= disp_mux(mode_q, op_a_q, op_b_q);
    end
  end

  assign bus.mode     = mode_q;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.disp_val = disp_q;

endmodule

// File: doc/adder_operand_ctrl.md
ADDER_OPERAND_CTRL -- requirements
Module: adder_operand_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CNT, default 1_000_000, meaning the number of consecutive stable clk cycles needed to accept a button level (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50_000_000, meaning the clk cycles a button is held before the first auto-repeat step.
REQ-003 The block SHALL have parameter REPEAT_RATE, default 10_000_000, meaning the clk cycles between subsequent auto-repeat steps.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 btn_sel  input  1  raw, asynchronous mode-select button.
REQ-008 btn_up  input  1  raw, asynchronous increment button.
REQ-009 btn_down  input  1  raw, asynchronous decrement button.
REQ-010 btn_clr  input  1  raw, asynchronous clear button.
REQ-011 disp_val  output  9  value sent to the FND controller's sum input (0..510).
REQ-012 op_a  output  8  operand A.
REQ-013 op_b  output  8  operand B.
REQ-014 mode  output  2  current state: 0 EDIT_A, 1 EDIT_B, 2 SHOW.

Function
REQ-015 Each raw button SHALL pass through a 2-flop synchronizer and then a debouncer.
- The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CNT consecutive cycles.
- Any bounce restarts the count.
REQ-016 A rising edge of a debounced level SHALL produce a registered one-cycle press pulse.
- Operand and state updates occur on the clk edge that registers that pulse.
- Total latency is DEBOUNCE_CNT+4 cycles from the first high sample of a clean raw press.
REQ-017 The FSM SHALL have states EDIT_A, EDIT_B and SHOW.
- A sel press moves EDIT_A->EDIT_B->SHOW->EDIT_A.
- Reset state is EDIT_A.
REQ-018 Up and down presses SHALL work as follows.
- In EDIT_A, up increments op_a and down decrements op_a; EDIT_B does the same for op_b.
- Arithmetic is modulo 256: 255+1=0, 0-1=255.
- In SHOW, up and down are ignored.
REQ-019 A clr press SHALL set op_a=0, op_b=0 and the state to EDIT_A, in any state.
REQ-020 Same-cycle press priority SHALL be clr > sel > up/down.
- Up and down together cause no operand change.
- When sel wins, up/down are discarded, not deferred.
REQ-021 disp_val SHALL be registered, with one cycle of latency after an operand or state change.
- EDIT_A: {1'b0,op_a}.
- EDIT_B: {1'b0,op_b}.
- SHOW: op_a+op_b, zero-extended to 9 bits with no overflow loss.
REQ-022 A held button SHALL produce only one press, unless auto-repeat is compiled in (REQ-027).

Reset
REQ-023 On reset the outputs SHALL be: op_a=0, op_b=0, mode=0 (EDIT_A), disp_val=0.
REQ-024 On reset, all synchronizers, debounced levels, debounce counters, edge registers and repeat counters SHALL clear to 0.
REQ-025 Reset asserted mid-debounce or mid-repeat SHALL abort the operation; no press is generated from pre-reset activity.
REQ-026 A button held through reset release SHALL register as a press once it has been debounced (DEBOUNCE_CNT+4 cycles).

Configuration
REQ-027 With macro ADDER_OPERAND_AUTO_REPEAT_EN defined, holding up or down SHALL generate extra steps.
- Applies only in EDIT_A/EDIT_B.
- First extra step occurs REPEAT_DELAY cycles after the initial press, then one every REPEAT_RATE cycles.
- Release or any other press stops the repeat.
REQ-028 Without ADDER_OPERAND_AUTO_REPEAT_EN, no repeat counters SHALL exist, REPEAT_DELAY and REPEAT_RATE are unused, and REQ-022 holds strictly.

Structure
REQ-029 A shared package SHALL hold the state encoding constants (EDIT_A=2'd0, EDIT_B=2'd1, SHOW=2'd2) and the operand width (8) and display width (9).
REQ-030 A sub-module btn_debounce SHALL contain the synchronizer, the debounce counter and the rising-edge pulse; it is instantiated four times.
REQ-031 The FSM, operand registers, repeat logic and disp_val mux SHALL be in the top module.

Verification
REQ-032 The bench SHALL use DEBOUNCE_CNT=4, REPEAT_DELAY=20 and REPEAT_RATE=5, and SHALL cover the following scenarios.
REQ-033 Reset: after reset, op_a=0, op_b=0, mode=0, disp_val=0; a clean up press then gives op_a=1 exactly 8 cycles after the first high sample, and disp_val=1 one cycle later.
REQ-034 Bounce: btn_up toggled with high periods of 1-3 cycles for 30 cycles then held low -> op_a unchanged; held high for 4+ stable cycles -> exactly one increment.
REQ-035 Wrap and sum:
- 255 up presses -> op_a=255, and one more press -> op_a=0.
- In EDIT_B, one down press -> op_b=255.
- With op_a=200 and op_b=255, sel into SHOW -> disp_val=455; up and down are ignored there.
REQ-036 Priority: clr and sel pressed on the same cycle -> mode=EDIT_A, op_a=op_b=0; up and down on the same cycle -> no change.
REQ-037 Mid-operation reset: reset asserted 2 cycles into a debounce -> no press after release; reset in SHOW -> mode=0 and disp_val=0 on the next cycle.
REQ-038 Auto-repeat (run both builds): hold up for 40 cycles after the press is accepted.
- With ADDER_OPERAND_AUTO_REPEAT_EN: op_a advances by 1 + 1 + floor((40-20)/5) = 6.
- Without the macro: op_a advances by 1.
